instr_mem_fetch: RTL and testbench
==================================

# instr_mem_fetch

Parametrised, synchronous instruction memory for the pipelined core's IF stage. Replaces the combinational, file-initialised instruction ROM with three additions:
- a registered read behind a valid/ready fetch handshake;
- a serial programming port that loads the program after reset;
- fault detection for misaligned and out-of-range fetch addresses.

It sits between the PC register/IF logic and the IF/ID pipeline register.

## Interface
- DATA_W, 32, instruction width in bits; multiple of 8.
- DEPTH, 64, number of instruction words; power of two, ≥ 2.
- ADDR_W, 32, fetch byte-address width.
- SKIP_LOAD, 0, 1 = leave reset directly in RUN, using only the initial contents.
- NOP_WORD, 32'h0000_0000, word returned on a faulting fetch.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- prog_valid  in  1  programming word present this cycle.
- prog_data  in  DATA_W  word to store at the current load pointer.
- prog_last  in  1  final word; qualified by prog_valid.
- loading  out  1  high while in LOAD.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_W  byte address.
- req_ready  out  1  request accepted when req_valid && req_ready.
- resp_valid  out  1  response present.
- resp_inst  out  DATA_W  fetched instruction.
- resp_fault  out  1  response was misaligned or out of range.
- resp_ready  in  1  consumer accepts the response.
- fault_sticky  out  1  set by any faulting accepted fetch; cleared only by reset.

## Operation
- Constants: OFF_W = log2(DATA_W/8), IDX_W = log2(DEPTH).
- FSM has two states, LOAD and RUN.
  - Reset enters LOAD, or RUN if SKIP_LOAD=1.
  - LOAD → RUN on prog_valid && prog_last, or on prog_valid when wptr == DEPTH-1.
  - RUN stays in RUN until reset.
- LOAD behaviour:
  - Each prog_valid cycle writes mem[wptr] ← prog_data, then wptr++.
  - wptr is IDX_W bits and resets to 0.
  - Words not written keep their prior contents.
  - req_ready = 0 in LOAD.
- Memory contents:
  - At time zero every word is NOP_WORD.
  - Memory is never cleared by rst_n.
- Fetch address decode:
  - idx = req_addr >> OFF_W.
  - fault = (req_addr[OFF_W-1:0] != 0) || (idx ≥ DEPTH); all upper address bits are checked.
  - resp_inst = fault ? NOP_WORD : mem[idx[IDX_W-1:0]].
- Handshake:
  - req_ready = RUN && (!resp_valid || resp_ready).
  - While resp_valid && !resp_ready, resp_inst and resp_fault hold stable.
  - prog_valid in RUN is ignored.

## Timing
- Reset values: resp_valid 0, resp_inst NOP_WORD, resp_fault 0, fault_sticky 0, wptr 0, loading 1 (0 if SKIP_LOAD).
- Fetch latency is 1 cycle: a request accepted at edge N has its response valid after edge N, and it is consumable in cycle N+1.
- Throughput is 1 fetch/cycle when resp_ready is held high.
- Read after load: a word written at edge N is readable by a fetch accepted at edge N+1 or later. The first RUN cycle follows the last write.
- Simultaneous response consumption and new request in the same cycle: the response is replaced with no bubble.
- Reset mid-operation: the in-flight response is dropped, resp_valid = 0 next cycle, and the FSM returns to LOAD with wptr = 0.
- Loading past DEPTH: wptr never wraps, because the FSM forces RUN at DEPTH-1.

## Structure
- Shared package `instr_mem_pkg`: the state encoding (S_LOAD, S_RUN) and the NOP_WORD default.
- OFF_W and IDX_W are local derived constants.
- One sub-module, `instr_mem_array`: a single-port write, synchronous-read DEPTH×DATA_W array with time-zero fill. Keep it separate so it can be swapped for a vendor RAM.
- FSM, address decode and handshake stay in the top level.

## Test plan
- Load sequence: reset, load 4 words 0x2008_0005, 0x2009_000A, 0x0109_5020, 0xAC0A_0000 with prog_last on the 4th.
  - loading falls the cycle after the 4th write.
  - Fetches at 0x0, 0x4, 0x8, 0xC return those words back-to-back with 1-cycle latency.
- Load boundary: DEPTH=8, stream 10 words with no prog_last → words 0–7 are stored, the FSM enters RUN after word 7, and words 8–9 are ignored.
- Faulting fetches:
  - Fetch 0x6 → resp_fault=1, resp_inst=0x0, fault_sticky=1.
  - Fetch 0x100 with DEPTH=64 → fault.
  - A following fetch at 0x0 → no fault; fault_sticky stays 1.
- Backpressure: hold resp_ready=0 for 3 cycles after a fetch at 0x4 → response stable, req_ready=0, no new accept. Release → the next request is accepted in the same cycle.
- Reset mid-operation: assert rst_n=0 for 1 cycle with resp_valid=1 → resp_valid=0 and loading=1 next cycle. Memory still returns the old words after SKIP-free reload of 0 words plus prog_last.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the IF-stage instruction memory: FSM state encoding
// and the default word returned on faulting fetches.
package instr_mem_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port-write, synchronous-read instruction storage, filled with a fixed
// word at time zero. Kept separate so a vendor RAM macro can replace it.
module instr_mem_array #(
    parameter int              DATA_W = 32,
    parameter int              DEPTH  = 64,
    parameter int              IDX_W  = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents survive reset; only the power-up image is defined.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: FILL};
    logic [DATA_W-1:0] r_rdata = FILL;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_fetch.sv
// IF-stage instruction memory: serial program load after reset, then registered
// fetches behind a valid/ready handshake with misaligned/out-of-range detection.
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter int                SKIP_LOAD = 0,
    parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              loading,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_inst,
    output logic              resp_fault,
    input  logic              resp_ready,
    output logic              fault_sticky
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_wptr;
    logic                r_respValid;
    logic                r_respFault;
    logic                r_faultSticky;

    logic [ADDR_W-1:0]   w_idx;
    logic                w_misaligned;
    logic                w_outOfRange;
    logic                w_fault;
    logic                w_accept;
    logic                w_progWrite;
    logic                w_lastSlot;
    logic [DATA_W-1:0]   w_rdata;

    // The full shifted address is compared so any set upper bit faults.
    assign w_idx        = req_addr >> OFF_W;
    assign w_misaligned = |(req_addr & OFF_MASK);
    assign w_outOfRange = w_idx >= ADDR_W'(DEPTH);
    assign w_fault      = w_misaligned || w_outOfRange;

    assign req_ready   = (r_state == S_RUN) && (!r_respValid || resp_ready);
    assign w_accept    = req_valid && req_ready;
    assign w_progWrite = (r_state == S_LOAD) && prog_valid;
    assign w_lastSlot  = (r_wptr == IDX_W'(DEPTH - 1));

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .FILL   (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .i_we    (w_progWrite),
        .i_waddr (r_wptr),
        .i_wdata (prog_data),
        .i_re    (w_accept && !w_fault),
        .i_raddr (w_idx[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= (SKIP_LOAD != 0) ? S_RUN : S_LOAD;
            r_wptr        <= '0;
            r_respValid   <= 1'b0;
            r_respFault   <= 1'b0;
            r_faultSticky <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (prog_valid) begin
                        if (!w_lastSlot) begin
                            r_wptr <= r_wptr + IDX_W'(1);
                        end
                        if (prog_last || w_lastSlot) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: ;
            endcase

            // A consumed response is replaced in the same cycle by a new accept.
            if (w_accept) begin
                r_respValid <= 1'b1;
                r_respFault <= w_fault;
                if (w_fault) begin
                    r_faultSticky <= 1'b1;
                end
            end else if (resp_ready) begin
                r_respValid <= 1'b0;
            end
        end
    end

    assign loading      = (r_state == S_LOAD);
    assign resp_valid   = r_respValid;
    assign resp_fault   = r_respFault;
    assign resp_inst    = (r_respValid && !r_respFault) ? w_rdata : NOP_WORD;
    assign fault_sticky = r_faultSticky;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboarded bench for instr_mem_fetch: a word-array model predicts every
// fetch response; a monitor process pops and compares on each consumed response.
module tb_instr_mem_fetch;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_last;
    logic        loading;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        resp_fault;
    logic        resp_ready;
    logic        fault_sticky;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] modelMem [DEPTH];
    bit          modelLoading;
    int          modelPtr;
    logic [32:0] expQ [$];
    bit          randReady = 1'b0;
    logic [31:0] loadBuf [70];

    always #5 clk = ~clk;

    instr_mem_fetch #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .SKIP_LOAD (0),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_valid   (prog_valid),
        .prog_data    (prog_data),
        .prog_last    (prog_last),
        .loading      (loading),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_inst    (resp_inst),
        .resp_fault   (resp_fault),
        .resp_ready   (resp_ready),
        .fault_sticky (fault_sticky)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Expected {fault, instruction} for a byte address, from word-array semantics.
    function automatic logic [32:0] modelFetch(input logic [31:0] addr);
        logic [32:0] r;
        if ((addr % 4) != 0 || (addr / 4) >= DEPTH) begin
            r = {1'b1, 32'h0000_0000};
        end else begin
            r = {1'b0, modelMem[addr / 4]};
        end
        return r;
    endfunction

    // Present one fetch and hold it until accepted; queue its expected response.
    task automatic applyStimulus(input logic [31:0] addr);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        if (randReady) resp_ready = ($urandom_range(0, 2) != 0);
        #1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            if (randReady) resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            waited++;
        end
        if (req_ready) begin
            expQ.push_back(modelFetch(addr));
        end else begin
            checkOutput("fetch_accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic applyIdle(input int n);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        modelLoading = 1'b1;
        modelPtr     = 0;
        #1;
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_inst", resp_inst, 0);
        checkOutput("rst_resp_fault", resp_fault, 0);
        checkOutput("rst_fault_sticky", fault_sticky, 0);
        checkOutput("rst_loading", loading, 1);
        checkOutput("rst_req_ready", req_ready, 0);
    endtask

    // Stream loadBuf[0..count-1]; prog_last rides on index lastIdx (-1 = never).
    task automatic applyLoad(input int count, input int lastIdx);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            prog_valid = 1'b1;
            prog_data  = loadBuf[i];
            prog_last  = (i == lastIdx);
            #1;
            checkOutput($sformatf("loading_w%0d", i), loading, modelLoading);
            if (modelLoading) checkOutput($sformatf("load_req_ready_w%0d", i), req_ready, 0);
            if (modelLoading) begin
                modelMem[modelPtr] = loadBuf[i];
                if (prog_last || modelPtr == DEPTH - 1) modelLoading = 1'b0;
                else modelPtr++;
            end
        end
        @(negedge clk);
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        #1;
        checkOutput("loading_after", loading, modelLoading);
    endtask

    // Monitor: checks response presence, hold stability and scoreboard contents.
    initial begin
        bit          expV     = 1'b0;
        bit          prevHeld = 1'b0;
        logic [31:0] prevInst = '0;
        logic        prevFault = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            checkOutput("resp_valid", resp_valid, expV);
            if (prevHeld && resp_valid) begin
                checkOutput("hold_inst", resp_inst, prevInst);
                checkOutput("hold_fault", resp_fault, prevFault);
            end
            if (rst_n && resp_valid && resp_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_inst", resp_inst, e[31:0]);
                    checkOutput("resp_fault", resp_fault, e[32]);
                end
            end
            if (!rst_n) begin
                expV     = 1'b0;
                prevHeld = 1'b0;
                expQ.delete();
            end else begin
                if (req_valid && req_ready) checkOutput("accept_while_loading", loading, 0);
                expV     = (req_valid && req_ready) || (resp_valid && !resp_ready);
                prevHeld = resp_valid && !resp_ready;
            end
            prevInst  = resp_inst;
            prevFault = resp_fault;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'h0000_0000;

        $display("[TB] reset and 4-word program load");
        applyReset();
        loadBuf[0] = 32'h2008_0005;
        loadBuf[1] = 32'h2009_000A;
        loadBuf[2] = 32'h0109_5020;
        loadBuf[3] = 32'hAC0A_0000;
        applyLoad(4, 3);
        applyStimulus(32'h0);
        applyStimulus(32'h4);
        applyStimulus(32'h8);
        applyStimulus(32'hC);
        applyStimulus(32'h10);
        applyIdle(3);
        checkOutput("sticky_before_fault", fault_sticky, 0);

        $display("[TB] faulting fetches");
        applyStimulus(32'h6);
        applyIdle(2);
        checkOutput("sticky_after_misaligned", fault_sticky, 1);
        applyStimulus(32'h100);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'hFC);
        applyStimulus(32'h0);
        applyIdle(2);
        checkOutput("sticky_holds", fault_sticky, 1);

        $display("[TB] backpressure");
        @(negedge clk);
        resp_ready = 1'b0;
        applyStimulus(32'h4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = 32'h8;
            #1;
            checkOutput($sformatf("bp_req_ready_%0d", k), req_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", req_ready, 1);
        if (req_ready) expQ.push_back(modelFetch(32'h8));
        applyIdle(3);

        $display("[TB] randomized fetches");
        randReady = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) applyStimulus(32'($urandom_range(0, DEPTH - 1)) * 4);
            else applyStimulus($urandom);
        end
        randReady = 1'b0;
        applyIdle(4);

        $display("[TB] load boundary: stream past the last slot");
        applyReset();
        for (int i = 0; i < 66; i++) loadBuf[i] = $urandom;
        applyLoad(66, -1);
        randReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(32'(i * 4));
        randReady = 1'b0;
        applyIdle(4);

        $display("[TB] reset with a response in flight");
        @(negedge clk);
        resp_ready = 1'b0;
        applyStimulus(32'h10);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checkOutput("pre_reset_valid", resp_valid, 1);
        applyReset();
        resp_ready = 1'b1;
        loadBuf[0] = 32'hDEAD_BEEF;
        applyLoad(1, 0);
        applyStimulus(32'h0);
        applyStimulus(32'h4);
        applyStimulus(32'h8);
        applyStimulus(32'hFC);
        applyIdle(5);
        checkOutput("queue_empty", 64'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
